// File: rtl/uart_pkg.sv
// Shared UART types and defaults used by the receive and transmit paths.
package uart_pkg;

  localparam int unsigned RX_FIFO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  function automatic rx_entry_t make_rx_entry(input logic [7:0] data, input logic parity_err,
                                              input logic frame_err);
    rx_entry_t entry;
    entry.frame_err  = frame_err;
    entry.parity_err = parity_err;
    entry.data       = data;
    return entry;
  endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Generic synchronous show-ahead FIFO; the head entry is read combinationally at rd_ptr.
module uart_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_level_next,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LW'(DEPTH));
  assign pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    level_d = level_q;
    if (i_flush) begin
      level_d = '0;
    end else if (push_ok & ~pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok & ~push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) mem[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata      = o_empty ? '0 : mem[rd_ptr_q];
  assign o_level      = level_q;
  assign o_level_next = level_d;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind uart_rx: edge-detected capture into a show-ahead FIFO, sticky overflow
// and hysteretic RTS generation.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned RTS_HIGH = 12,
  parameter int unsigned RTS_LOW  = 4,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_rx_done,
  input  logic [8:0]    i_rx_word,
  input  logic          i_rx_parity_error,
  input  logic          i_rx_frame_error,
  input  logic          i_hw_flow_control_enable,
  input  logic          i_flush,
  input  logic          i_overflow_clear,
  input  logic          i_rd_ready,
  output logic          o_rd_valid,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_parity_error,
  output logic          o_rd_frame_error,
  output logic [LW-1:0] o_level,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_overflow,
  output logic          o_rts_n
);

  logic          done_q;
  logic          overflow_q;
  logic          rts_q;
  logic          rts_d;
  logic          push;
  logic          pop;
  logic          overflow_set;
  logic [LW-1:0] level_next;
  rx_entry_t     wr_entry;
  rx_entry_t     rd_entry;

  // done_q resets low so a done already high at reset release still yields one push.
  assign push     = i_rx_done & ~done_q;
  assign pop      = o_rd_valid & i_rd_ready;
  assign wr_entry = make_rx_entry(i_rx_word[7:0], i_rx_parity_error, i_rx_frame_error);

  uart_fifo_sync #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_push      (push),
    .i_wdata     (wr_entry),
    .i_pop       (pop),
    .i_flush     (i_flush),
    .o_rdata     (rd_entry),
    .o_level     (o_level),
    .o_level_next(level_next),
    .o_full      (o_full),
    .o_empty     (o_empty)
  );

  // A push discarded by a flush is not counted as a dropped character.
  assign overflow_set = push & o_full & ~pop & ~i_flush;

  always_comb begin
    rts_d = rts_q;
    if (!i_hw_flow_control_enable) begin
      rts_d = 1'b0;
    end else if (level_next >= LW'(RTS_HIGH)) begin
      rts_d = 1'b1;
    end else if (level_next <= LW'(RTS_LOW)) begin
      rts_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      rts_q      <= 1'b1;
    end else begin
      done_q <= i_rx_done;
      rts_q  <= rts_d;
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end else if (i_overflow_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign o_rd_valid        = ~o_empty;
  assign o_rd_data         = rd_entry.data;
  assign o_rd_parity_error = rd_entry.parity_err;
  assign o_rd_frame_error  = rd_entry.frame_err;
  assign o_overflow        = overflow_q;
  assign o_rts_n           = rts_q;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side buffer directly downstream of uart_rx.
- Captures each completed character (data plus parity/frame error flags) into a show-ahead FIFO and presents it to the register/bus side with a valid/ready handshake.
- Reports fill level and a sticky overflow flag.
- Generates the RTS flow-control output with hysteresis when hardware flow control is enabled.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- RTS_HIGH, 12: when the level is >= this, o_rts_n deasserts (goes high). Must satisfy RTS_LOW < RTS_HIGH <= DEPTH.
- RTS_LOW, 4: when the level is <= this, o_rts_n reasserts (goes low).

Ports:
- i_clk, input, 1: clock.
- i_nrst, input, 1: asynchronous active-low reset.
- i_rx_done, input, 1: character complete, from uart_rx (level; edge-detected here).
- i_rx_word, input, 9: [7:0] data, [8] received parity bit.
- i_rx_parity_error, input, 1: parity error qualifier, valid with i_rx_done.
- i_rx_frame_error, input, 1: frame error qualifier, valid with i_rx_done.
- i_hw_flow_control_enable, input, 1: enables RTS generation.
- i_flush, input, 1: synchronous FIFO clear.
- i_overflow_clear, input, 1: clears the sticky overflow flag.
- i_rd_ready, input, 1: consumer accepts the head entry.
- o_rd_valid, output, 1: head entry available.
- o_rd_data, output, 8: head data.
- o_rd_parity_error, output, 1: head entry's parity error flag.
- o_rd_frame_error, output, 1: head entry's frame error flag.
- o_level, output, $clog2(DEPTH)+1: current occupancy.
- o_empty, output, 1: o_level == 0.
- o_full, output, 1: o_level == DEPTH.
- o_overflow, output, 1: sticky; a character was dropped.
- o_rts_n, output, 1: active-low request-to-send.

Behaviour:
- Reset values:
  - Pointers and level 0; o_rd_valid 0; o_empty 1; o_full 0; o_overflow 0; o_rts_n 1.
  - Internal done_q 0. Memory contents are don't-care; o_rd_data and the error flags read as 0 while empty.
- Push detect:
  - push = i_rx_done & ~done_q, with done_q a register of i_rx_done.
  - Exactly one push per rising edge, however long i_rx_done stays high.
  - If i_rx_done is high when reset releases, one push occurs.
- Stored entry: {i_rx_frame_error, i_rx_parity_error, i_rx_word[7:0]}, sampled in the push cycle. i_rx_word[8] is not stored.
- Latency: a push in cycle N gives o_rd_valid = 1 and the entry visible in cycle N+1 (show-ahead; head read combinationally from memory at rd_ptr).
- Pop:
  - pop = o_rd_valid & i_rd_ready. The head advances on that clock edge.
  - o_rd_valid = ~o_empty.
  - Outputs must stay stable while valid & ~ready.
- Level update: +1 on push only; -1 on pop only; unchanged on both together. Pointers wrap modulo DEPTH.
- Full boundary:
  - push & full & ~pop: character dropped, memory and pointers unchanged, o_overflow set next cycle.
  - push & full & pop: both accepted, no overflow.
- Empty boundary: a pop cannot occur while empty. A push into an empty FIFO is not readable in the same cycle.
- Flush:
  - i_flush zeroes the pointers and level at the next edge; it has priority over push and pop in the same cycle (both discarded).
  - Flush does not clear o_overflow.
- Overflow flag: i_overflow_clear clears it. If clear and a new overflow occur in the same cycle, set wins.
- RTS, registered:
  - If ~i_hw_flow_control_enable: o_rts_n goes to 0 next cycle.
  - Otherwise, based on the next-state level: set to 1 when level >= RTS_HIGH; cleared to 0 when level <= RTS_LOW; held between the thresholds (hysteresis).
  - First cycle after reset: re-evaluated normally.
- Reset mid-operation: all state returns to reset values asynchronously. Data in flight is lost.

Decomposition:
- uart_pkg additions:
  - typedef struct packed rx_entry_t {logic frame_err; logic parity_err; logic [7:0] data;}.
  - localparam RX_FIFO_DEPTH_DEFAULT = 16.
- One sub-module, uart_fifo_sync: generic synchronous show-ahead FIFO parameterised by WIDTH and DEPTH, with push, pop, flush, level, full and empty.
- uart_rx_buffer adds edge detect, overflow and RTS logic around uart_fifo_sync.
- uart_fifo_sync is reused later by the TX path.

Test Plan:
- Single char: i_rx_done pulse with word 9'h0A5 and no errors → next cycle o_rd_valid=1, o_rd_data=8'hA5, o_level=1. Pop with i_rd_ready=1 → o_empty=1.
- Long done: i_rx_done held high for 5 cycles with 8'h3C → o_level=1 (one push only).
- Fill/overflow:
  - 16 pushes of 8'h00..8'h0F → o_full=1.
  - 17th push of 8'hFF → o_overflow=1 and o_level=16; reads return 00..0F, with no FF.
  - i_overflow_clear → o_overflow=0.
- Full push+pop: with the FIFO full, push 8'h55 while popping → o_level stays 16, no overflow; 8'h55 is read last.
- RTS hysteresis (flow control enabled, DEPTH 16, 12/4):
  - o_rts_n=0 at level 11, goes 1 at level 12.
  - Pops down to 5 keep it 1; reaching 4 drives it 0.
  - Disabling flow control at level 14 → o_rts_n=0 next cycle.
- Flush and errors:
  - Push 8'h81 with frame_err=1, then 8'h42 with parity_err=1 → the head shows frame_err=1; after a pop, parity_err=1.
  - Push 3 entries then i_flush with a simultaneous push → o_level=0, o_empty=1, o_overflow unchanged.
